eprom2716_prog_ctrl: RTL and testbench

//  Sequencer that reads and programs a 2716 2Kx8 EPROM in the simulated Nascom hardware.
//  - Host issues single-byte READ or PROGRAM commands.
//  - Block drives the EPROM address, data, CE/PGM, OE and VPP pins with correct phase timing.
//  - PROGRAM is followed by a verify read and a bounded number of re-pulses.
//  - Sits between a host/bench command port and the eprom2716 pin model.

---
 rtl/eprom2716_prog_ctrl_if.sv | 13 +
 rtl/eprom2716_prog_ctrl.sv | 92 +++++++++
 tb/tb_eprom2716_prog_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eprom2716_prog_ctrl_if.sv
// eprom2716_prog_ctrl_if: host command port of the 2716 read/program sequencer
interface eprom2716_prog_ctrl_if;
  logic start;
  logic prog;
  logic [10:0] addr;
  logic [7:0] wdata;
  logic busy;
  logic done;
  logic fail;
  logic [7:0] rdata;
  modport master(output start, prog, addr, wdata, input busy, done, fail, rdata);
  modport slave(input start, prog, addr, wdata, output busy, done, fail, rdata);
endinterface

// File: rtl/eprom2716_prog_ctrl.sv
// eprom2716_prog_ctrl: reads and programs a 2716 EPROM with verify and bounded re-pulsing
module eprom2716_prog_ctrl #(
  parameter int VPP_SETTLE = 16,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 200000,
  parameter int HOLD_CYC = 4,
  parameter int READ_CYC = 3,
  parameter int MAX_TRY = 25,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst,
  eprom2716_prog_ctrl_if.slave host,
  output logic [10:0] e_a,
  output logic [7:0] e_d_out,
  output logic e_d_oe,
  input  logic [7:0] e_d_in,
  output logic e_cs_n,
  output logic e_oe_n,
  output logic e_vpp
);
  typedef enum logic [3:0] {IDLE, RD, VPP_ON, SETUP, PULSE, HOLD, VFY, CHECK, DONE} state_t;
  localparam int TRY_W = $clog2(MAX_TRY + 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] tmr, tmr_ld;
  logic [TRY_W-1:0] try_cnt;
  logic [7:0] rdata_q;
  logic fail_q, t_end, vfy_turn;
  assign t_end = tmr == '0;
  // first VFY cycle only releases the data bus before OE_n drops
  assign vfy_turn = state == VFY && tmr == CNT_W'(READ_CYC);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = host.start ? (host.prog ? VPP_ON : RD) : IDLE;
      RD:     state_nx = t_end ? DONE : RD;
      VPP_ON: state_nx = t_end ? SETUP : VPP_ON;
      SETUP:  state_nx = t_end ? PULSE : SETUP;
      PULSE:  state_nx = t_end ? HOLD : PULSE;
      HOLD:   state_nx = t_end ? VFY : HOLD;
      VFY:    state_nx = t_end ? CHECK : VFY;
      CHECK:  state_nx = (rdata_q == e_d_out || try_cnt >= TRY_W'(MAX_TRY)) ? DONE : SETUP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    tmr_ld = '0;
    case (state_nx)
      RD:     tmr_ld = CNT_W'(READ_CYC - 1);
      VPP_ON: tmr_ld = CNT_W'(VPP_SETTLE - 1);
      SETUP:  tmr_ld = CNT_W'(SETUP_CYC - 1);
      PULSE:  tmr_ld = CNT_W'(PULSE_CYC - 1);
      HOLD:   tmr_ld = CNT_W'(HOLD_CYC - 1);
      VFY:    tmr_ld = CNT_W'(READ_CYC);
      default: tmr_ld = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      try_cnt <= '0;
      rdata_q <= '0;
      fail_q <= 1'b0;
      e_a <= '0;
      e_d_out <= '0;
    end else begin
      state <= state_nx;
      tmr <= (state_nx != state) ? tmr_ld : (t_end ? tmr : tmr - 1'b1);
      if (state == IDLE && host.start) begin
        e_a <= host.addr;
        e_d_out <= host.wdata;
        try_cnt <= '0;
        fail_q <= 1'b0;
      end
      if (state_nx == PULSE && state != PULSE) try_cnt <= try_cnt + 1'b1;
      if ((state == RD || state == VFY) && t_end) rdata_q <= e_d_in;
      if (state == CHECK && state_nx == DONE) fail_q <= rdata_q != e_d_out;
    end
  // pins decode straight from the state so an async reset makes them safe at once
  assign e_vpp = state inside {VPP_ON, SETUP, PULSE, HOLD, VFY, CHECK};
  assign e_cs_n = !(state inside {RD, VPP_ON, HOLD, VFY});
  assign e_oe_n = !(state == RD || (state == VFY && !vfy_turn));
  assign e_d_oe = state inside {VPP_ON, SETUP, PULSE, HOLD};
  assign host.busy = state != IDLE && state != DONE;
  assign host.done = state == DONE;
  assign host.fail = fail_q;
  assign host.rdata = rdata_q;
  a_no_fight: assert property (@(posedge clk) disable iff (rst) !(e_d_oe && !e_oe_n));
  a_vpp_safe: assert property (@(posedge clk) disable iff (rst) (state inside {IDLE, RD}) |-> !e_vpp);
  a_addr_hold: assert property (@(posedge clk) disable iff (rst) (host.busy && $past(host.busy)) |-> $stable(e_a));
endmodule

// File: tb/tb_eprom2716_prog_ctrl.sv
// tb_eprom2716_prog_ctrl: randomized commands against a pin-level 2716 model and a latency/pulse reference model
module tb_eprom2716_prog_ctrl;
  localparam int VPP_SETTLE = 2, SETUP_CYC = 4, PULSE_CYC = 8, HOLD_CYC = 4, READ_CYC = 3, MAX_TRY = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] e_a;
  logic [7:0] e_d_out, e_d_in;
  logic e_d_oe, e_cs_n, e_oe_n, e_vpp;
  int checks = 0, failures = 0;
  eprom2716_prog_ctrl_if host();
  eprom2716_prog_ctrl #(.VPP_SETTLE(VPP_SETTLE), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC(HOLD_CYC), .READ_CYC(READ_CYC), .MAX_TRY(MAX_TRY), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .host(host), .e_a(e_a), .e_d_out(e_d_out), .e_d_oe(e_d_oe),
    .e_d_in(e_d_in), .e_cs_n(e_cs_n), .e_oe_n(e_oe_n), .e_vpp(e_vpp));
  always #5 clk = ~clk;
  // EPROM: reads 0xAA only once CE_n/OE_n have been low for the access time, else 0xFF
  int rd_cnt = 0;
  always @(posedge clk) rd_cnt <= (!e_cs_n && !e_oe_n) ? rd_cnt + 1 : 0;
  assign e_d_in = (!e_cs_n && !e_oe_n && rd_cnt >= READ_CYC - 1) ? 8'hAA : 8'hFF;
  int viol = 0, hi_run = 0, hold_run = 0, done_cnt = 0;
  int hi_q[$], hold_q[$];
  bit after_hi = 1'b0, rd_cmd = 1'b0;
  logic [10:0] a_cap = '0;
  logic [7:0] d_cap = '0;
  // per-cycle invariant watch and PGM/HOLD phase length recorder
  always @(negedge clk)
    if (rst) begin
      hi_run = 0;
      hold_run = 0;
      after_hi = 1'b0;
    end else begin
      if (e_d_oe && !e_oe_n) viol++;
      if (e_vpp && (!host.busy || rd_cmd)) viol++;
      if (host.busy && e_a !== a_cap) viol++;
      if (e_d_oe && e_d_out !== d_cap) viol++;
      if (host.done) done_cnt++;
      if (e_vpp && e_cs_n && e_d_oe) hi_run++;
      else if (hi_run > 0) begin hi_q.push_back(hi_run); hi_run = 0; after_hi = 1'b1; end
      if (after_hi && e_vpp && !e_cs_n && e_d_oe) hold_run++;
      else if (hold_run > 0) begin hold_q.push_back(hold_run); hold_run = 0; after_hi = 1'b0; end
    end
  function automatic int exp_tries(bit p, logic [7:0] d);
    return !p ? 0 : (d == 8'hAA ? 1 : MAX_TRY);
  endfunction
  function automatic int exp_lat(bit p, logic [7:0] d);
    return !p ? READ_CYC + 1 :
      VPP_SETTLE + exp_tries(p, d) * (SETUP_CYC + PULSE_CYC + HOLD_CYC + 1 + READ_CYC + 1) + 1;
  endfunction
  task automatic issue(input bit p, input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    a_cap = a; d_cap = d; rd_cmd = !p;
    host.start = 1'b1; host.prog = p; host.addr = a; host.wdata = d;
    @(posedge clk);
    #1;
    host.start = 1'b0; host.prog = 1'($urandom); host.addr = 11'($urandom); host.wdata = 8'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (host.done !== 1'b1 && lat < 500) begin @(negedge clk); lat++; end
  endtask
  task automatic test_reset;
    int n = 0;
    host.start = 1'b0; host.prog = 1'b0; host.addr = '0; host.wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({host.busy, host.done, host.fail, host.rdata, e_a, e_d_out, e_d_oe, e_cs_n, e_oe_n, e_vpp} !== {3'b000, 8'h00, 11'h000, 8'h00, 4'b0110}) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b fail=%b rdata=%h a=%h d=%h oe=%b cs_n=%b oe_n=%b vpp=%b want idle/zero/cs_n=oe_n=1",
        host.busy, host.done, host.fail, host.rdata, e_a, e_d_out, e_d_oe, e_cs_n, e_oe_n, e_vpp);
    end
    rst = 1'b0;
    issue(1'b1, 11'h2B4, 8'hAA);
    while (hi_run < SETUP_CYC + 3 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!(e_vpp === 1'b1 && e_cs_n === 1'b1 && n < 200)) begin failures++; $display("FAIL reset_reach_pulse vpp=%b cs_n=%b waited=%0d want vpp=1 cs_n=1", e_vpp, e_cs_n, n); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({e_vpp, e_cs_n, e_d_oe, host.busy} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_mid_pulse got vpp=%b cs_n=%b d_oe=%b busy=%b want 0 1 0 0", e_vpp, e_cs_n, e_d_oe, host.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = done_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != n || host.busy !== 1'b0 || e_vpp !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_retry got extra_done=%0d busy=%b vpp=%b want 0 0 0", done_cnt - n, host.busy, e_vpp);
    end
  endtask
  task automatic test_read;
    int lat, v0 = viol;
    issue(1'b0, 11'h7FF, 8'h00);
    checks++;
    if (host.busy !== 1'b1 || e_a !== 11'h7FF) begin failures++; $display("FAIL read_start got busy=%b a=%h want 1 7ff", host.busy, e_a); end
    wait_done(lat);
    checks++;
    if (lat != READ_CYC + 1) begin failures++; $display("FAIL read_lat got %0d want %0d", lat, READ_CYC + 1); end
    checks++;
    if (host.rdata !== 8'hAA || host.fail !== 1'b0) begin failures++; $display("FAIL read_data got rdata=%h fail=%b want aa 0", host.rdata, host.fail); end
    @(negedge clk);
    checks++;
    if (viol != v0 || host.busy !== 1'b0 || host.rdata !== 8'hAA) begin
      failures++;
      $display("FAIL read_after got viol=%0d busy=%b rdata=%h want 0 0 aa", viol - v0, host.busy, host.rdata);
    end
  endtask
  task automatic test_program(input string tag, input logic [10:0] a, input logic [7:0] d);
    int lat, v0 = viol, h0 = hi_q.size(), k0 = hold_q.size(), tries = exp_tries(1'b1, d);
    issue(1'b1, a, d);
    wait_done(lat);
    checks++;
    if (lat != exp_lat(1'b1, d)) begin failures++; $display("FAIL %s_lat got %0d want %0d", tag, lat, exp_lat(1'b1, d)); end
    checks++;
    if (host.fail !== (d != 8'hAA) || host.rdata !== 8'hAA || e_a !== a) begin
      failures++;
      $display("FAIL %s_result got fail=%b rdata=%h a=%h want %b aa %h", tag, host.fail, host.rdata, e_a, d != 8'hAA, a);
    end
    checks++;
    if (hi_q.size() - h0 != tries || hold_q.size() - k0 != tries) begin
      failures++;
      $display("FAIL %s_pulses got pgm=%0d hold=%0d want %0d", tag, hi_q.size() - h0, hold_q.size() - k0, tries);
    end
    for (int i = h0; i < hi_q.size(); i++) begin
      checks++;
      if (hi_q[i] != SETUP_CYC + PULSE_CYC) begin failures++; $display("FAIL %s_setup_pulse got %0d want %0d", tag, hi_q[i], SETUP_CYC + PULSE_CYC); end
    end
    for (int i = k0; i < hold_q.size(); i++) begin
      checks++;
      if (hold_q[i] != HOLD_CYC) begin failures++; $display("FAIL %s_hold got %0d want %0d", tag, hold_q[i], HOLD_CYC); end
    end
    @(negedge clk);
    checks++;
    if (viol != v0 || e_vpp !== 1'b0 || host.busy !== 1'b0 || host.fail !== (d != 8'hAA)) begin
      failures++;
      $display("FAIL %s_after got viol=%0d vpp=%b busy=%b fail=%b want 0 0 0 %b", tag, viol - v0, e_vpp, host.busy, host.fail, d != 8'hAA);
    end
  endtask
  task automatic test_busy_start;
    int lat = 0, v0 = viol, d0 = done_cnt, h0 = hi_q.size();
    issue(1'b1, 11'h3C5, 8'hAA);
    while (host.done !== 1'b1 && lat < 500) begin
      @(negedge clk);
      lat++;
      host.start = (lat == 10 || lat == 20);
      host.prog = lat[0]; host.addr = 11'h5A5; host.wdata = 8'h55;
    end
    host.start = 1'b0;
    checks++;
    if (lat != exp_lat(1'b1, 8'hAA)) begin failures++; $display("FAIL busy_start_lat got %0d want %0d", lat, exp_lat(1'b1, 8'hAA)); end
    checks++;
    if (e_a !== 11'h3C5 || e_d_out !== 8'hAA || host.fail !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_capture got a=%h d=%h fail=%b want 3c5 aa 0", e_a, e_d_out, host.fail);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || hi_q.size() - h0 != 1 || viol != v0 || host.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_single got dones=%0d pulses=%0d viol=%0d busy=%b want 1 1 0 0", done_cnt - d0, hi_q.size() - h0, viol - v0, host.busy);
    end
  endtask
  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      bit p = 1'($urandom);
      logic [10:0] a = 11'($urandom);
      logic [7:0] d = $urandom_range(0, 1) ? 8'hAA : 8'($urandom);
      int lat, v0 = viol, h0 = hi_q.size();
      issue(p, a, d);
      wait_done(lat);
      checks++;
      if (lat != exp_lat(p, d) || host.rdata !== 8'hAA || host.fail !== (p && d != 8'hAA) || e_a !== a) begin
        failures++;
        $display("FAIL rand%0d got lat=%0d rdata=%h fail=%b a=%h want %0d aa %b %h (prog=%b wdata=%h)",
          it, lat, host.rdata, host.fail, e_a, exp_lat(p, d), p && d != 8'hAA, a, p, d);
      end
      @(negedge clk);
      checks++;
      if (hi_q.size() - h0 != exp_tries(p, d) || viol != v0) begin
        failures++;
        $display("FAIL rand%0d_pins got pulses=%0d viol=%0d want %0d 0", it, hi_q.size() - h0, viol - v0, exp_tries(p, d));
      end
    end
  endtask
  initial begin
    test_reset;
    test_read;
    test_program("prog_pass", 11'h123, 8'hAA);
    test_program("prog_fail", 11'h0F0, 8'h55);
    test_busy_start;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
